uart_rx: RTL and testbench

- 16x-oversampling UART receiver. Sits directly downstream of the baud generator and consumes its 16x-rate tick (baud_tick2) as baud_tick16.
- Synchronises the asynchronous serial line, validates the start bit at mid-bit and samples data LSB-first.
- Optionally checks parity, checks the stop bit, and presents each byte on a valid/ready interface with error and overrun flags.

---
 rtl/uart_rx.sv | 169 ++++++++++++++++
 tb/tb_uart_rx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: start-bit validation at mid-bit, LSB-first data,
// optional parity, stop-bit check and a valid/ready output with error/overrun flags.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | line high, waiting for a falling edge
// START     | counting to mid start bit to reject glitches
// DATA      | sampling DATA_BITS data bits at mid-bit
// PARITY    | sampling the parity bit
// STOP      | sampling the stop bit, publishing the byte
// WAIT_IDLE | line low after reset or a bad stop bit; wait for it to go high
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick16,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int   BW       = $clog2(DATA_BITS + 1);
    localparam logic PAR_ODD  = (PARITY_ODD != 0);
    localparam logic PAR_EN   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta, rx_s;
    logic [3:0]           tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 pbad_q, pbad_d;
    logic                 complete;
    logic                 mid_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_WAIT_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            pbad_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            pbad_q  <= pbad_d;
        end
    end

    assign mid_bit = baud_tick16 && (tick_q == 4'd15);

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        pbad_d   = pbad_q;
        complete = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    tick_d  = '0;
                end
            end
            S_START: begin
                if (baud_tick16) begin
                    if (tick_q == 4'd7) begin
                        tick_d = '0;
                        if (!rx_s) begin
                            state_d = S_DATA;
                            bit_d   = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (mid_bit) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    tick_d  = '0;
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BW'(DATA_BITS - 1))
                        state_d = PAR_EN ? S_PARITY : S_STOP;
                end else if (baud_tick16) begin
                    tick_d = tick_q + 4'd1;
                end
            end
            S_PARITY: begin
                if (mid_bit) begin
                    pbad_d  = (^shift_q) ^ rx_s ^ PAR_ODD;
                    tick_d  = '0;
                    state_d = S_STOP;
                end else if (baud_tick16) begin
                    tick_d = tick_q + 4'd1;
                end
            end
            S_STOP: begin
                if (mid_bit) begin
                    complete = 1'b1;
                    tick_d   = '0;
                    // A low stop bit may be the start of a break; hold off until the line recovers.
                    state_d  = rx_s ? S_IDLE : S_WAIT_IDLE;
                end else if (baud_tick16) begin
                    tick_d = tick_q + 4'd1;
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s)
                    state_d = S_IDLE;
            end
            default: state_d = S_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= complete && rx_valid && !rx_ready;
            if (complete) begin
                rx_data    <= shift_q;
                frame_err  <= ~rx_s;
                parity_err <= PAR_EN && pbad_q;
                rx_valid   <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8N1 instance and an 8E1 instance share clock,
// reset and baud tick; each has its own serial line.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       baud_tick16;
    logic       rx, rx_p;
    logic       rx_ready;
    logic [7:0] rx_data, rx_data_p;
    logic       rx_valid, rx_valid_p;
    logic       frame_err, frame_err_p;
    logic       parity_err, parity_err_p;
    logic       overrun, overrun_p;
    logic       busy, busy_p;
    logic       ready_p;

    int checks = 0;
    int errors = 0;
    int tcnt;

    int         nbytes = 0, nbytes_p = 0, novr = 0;
    logic       prev_v = 1'b0, prev_v_p = 1'b0;
    logic [7:0] last_data, last_data_p;
    logic       last_ferr, last_perr, last_ferr_p, last_perr_p;

    uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
        .clk(clk), .rst(rst), .baud_tick16(baud_tick16), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
    );

    uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_p (
        .clk(clk), .rst(rst), .baud_tick16(baud_tick16), .rx(rx_p),
        .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(ready_p),
        .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun(overrun_p), .busy(busy_p)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One tick every 4 clk, so one bit is 64 clk.
    initial begin
        tcnt        = 0;
        baud_tick16 = 1'b0;
        forever begin
            @(negedge clk);
            tcnt        = (tcnt + 1) % 4;
            baud_tick16 = (tcnt == 0);
        end
    end

    always @(negedge clk) begin
        prev_v   <= rx_valid;
        prev_v_p <= rx_valid_p;
        if (rx_valid && !prev_v) begin
            nbytes    <= nbytes + 1;
            last_data <= rx_data;
            last_ferr <= frame_err;
            last_perr <= parity_err;
        end
        if (rx_valid_p && !prev_v_p) begin
            nbytes_p    <= nbytes_p + 1;
            last_data_p <= rx_data_p;
            last_ferr_p <= frame_err_p;
            last_perr_p <= parity_err_p;
        end
        if (overrun)
            novr <= novr + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Start bit begins just before a tick edge, so the stop-bit mid-sample lands
    // exactly 32 clk into the stop bit; ready_pulse raises rx_ready for that clk only.
    task automatic send_frame(input logic sel_p, input logic [7:0] data, input logic par_bit,
                              input logic stop_bit, input logic ready_pulse);
        do begin
            @(negedge clk);
            #1;
        end while (!baud_tick16);
        if (sel_p) rx_p = 1'b0; else rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (64) @(negedge clk);
            #1;
            if (sel_p) rx_p = data[i]; else rx = data[i];
        end
        if (sel_p) begin
            repeat (64) @(negedge clk);
            #1;
            rx_p = par_bit;
        end
        repeat (64) @(negedge clk);
        #1;
        if (sel_p) rx_p = stop_bit; else rx = stop_bit;
        repeat (32) @(negedge clk);
        #1;
        if (ready_pulse) rx_ready = 1'b1;
        @(negedge clk);
        #1;
        if (ready_pulse) rx_ready = 1'b0;
        repeat (31) @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx   = 1'b1;
        rx_p = 1'b1;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; rx = 1'b1; rx_p = 1'b1; rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
        checks++; if (parity_err_p !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", parity_err_p); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
        checks++; if (busy_p !== 1'b0) begin errors++; $display("FAIL reset_release_busy_p: got %b expected 0", busy_p); end
    endtask

    task automatic test_basic;
        int n0, o0;
        n0 = nbytes; o0 = novr;
        send_frame(1'b0, 8'h55, 1'b0, 1'b1, 1'b0);
        idle(100);
        checks++; if (nbytes !== n0 + 1) begin errors++; $display("FAIL basic_count: got %0d expected %0d", nbytes - n0, 1); end
        checks++; if (last_data !== 8'h55) begin errors++; $display("FAIL basic_data: got %h expected 55", last_data); end
        checks++; if (last_ferr !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b expected 0", last_ferr); end
        checks++; if (last_perr !== 1'b0) begin errors++; $display("FAIL basic_perr: got %b expected 0", last_perr); end
        checks++; if (novr !== o0) begin errors++; $display("FAIL basic_overrun: got %0d pulses expected 0", novr - o0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", busy); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_cleared: got %b expected 0", rx_valid); end
    endtask

    task automatic test_glitch;
        int n0;
        n0 = nbytes;
        rx = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b expected 1", busy); end
        repeat (8) @(negedge clk);
        #1;
        idle(200);
        checks++; if (nbytes !== n0) begin errors++; $display("FAIL glitch_count: got %0d expected 0", nbytes - n0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_parity;
        int n0;
        n0 = nbytes_p;
        send_frame(1'b1, 8'hA3, 1'b0, 1'b1, 1'b0);
        idle(100);
        checks++; if (nbytes_p !== n0 + 1) begin errors++; $display("FAIL par_good_count: got %0d expected 1", nbytes_p - n0); end
        checks++; if (last_data_p !== 8'hA3) begin errors++; $display("FAIL par_good_data: got %h expected a3", last_data_p); end
        checks++; if (last_perr_p !== 1'b0) begin errors++; $display("FAIL par_good_perr: got %b expected 0", last_perr_p); end
        send_frame(1'b1, 8'hA3, 1'b1, 1'b1, 1'b0);
        idle(100);
        checks++; if (nbytes_p !== n0 + 2) begin errors++; $display("FAIL par_bad_count: got %0d expected 2", nbytes_p - n0); end
        checks++; if (last_data_p !== 8'hA3) begin errors++; $display("FAIL par_bad_data: got %h expected a3", last_data_p); end
        checks++; if (last_perr_p !== 1'b1) begin errors++; $display("FAIL par_bad_perr: got %b expected 1", last_perr_p); end
        checks++; if (last_ferr_p !== 1'b0) begin errors++; $display("FAIL par_bad_ferr: got %b expected 0", last_ferr_p); end
        checks++; if (parity_err_p !== 1'b1) begin errors++; $display("FAIL par_flag_held: got %b expected 1", parity_err_p); end
    endtask

    task automatic test_break;
        int n0;
        n0 = nbytes;
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (30 * 64) @(negedge clk);
        #1;
        checks++; if (nbytes !== n0 + 1) begin errors++; $display("FAIL break_count: got %0d expected 1", nbytes - n0); end
        checks++; if (last_data !== 8'h3C) begin errors++; $display("FAIL break_data: got %h expected 3c", last_data); end
        checks++; if (last_ferr !== 1'b1) begin errors++; $display("FAIL break_ferr: got %b expected 1", last_ferr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy_low: got %b expected 1", busy); end
        idle(200);
        checks++; if (nbytes !== n0 + 1) begin errors++; $display("FAIL break_count_after: got %0d expected 1", nbytes - n0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_busy_high: got %b expected 0", busy); end
    endtask

    task automatic test_overrun;
        int n0, o0;
        n0 = nbytes; o0 = novr;
        rx_ready = 1'b0;
        send_frame(1'b0, 8'h11, 1'b0, 1'b1, 1'b0);
        idle(100);
        checks++; if (nbytes !== n0 + 1) begin errors++; $display("FAIL ovr_first_count: got %0d expected 1", nbytes - n0); end
        checks++; if (last_data !== 8'h11) begin errors++; $display("FAIL ovr_first_data: got %h expected 11", last_data); end
        checks++; if (novr !== o0) begin errors++; $display("FAIL ovr_first_pulse: got %0d expected 0", novr - o0); end
        send_frame(1'b0, 8'h22, 1'b0, 1'b1, 1'b0);
        idle(100);
        checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL ovr_second_data: got %h expected 22", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_second_valid: got %b expected 1", rx_valid); end
        checks++; if (novr !== o0 + 1) begin errors++; $display("FAIL ovr_second_pulse: got %0d expected 1", novr - o0); end
        send_frame(1'b0, 8'h33, 1'b0, 1'b1, 1'b1);
        idle(100);
        checks++; if (rx_data !== 8'h33) begin errors++; $display("FAIL ovr_third_data: got %h expected 33", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_third_valid: got %b expected 1", rx_valid); end
        checks++; if (novr !== o0 + 1) begin errors++; $display("FAIL ovr_third_pulse: got %0d expected 1", novr - o0); end
        rx_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept: got %b expected 0", rx_valid); end
    endtask

    task automatic test_reset_mid;
        int n0;
        n0 = nbytes;
        rx_ready = 1'b1;
        rx = 1'b0;
        repeat (80) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rmid_ferr: got %b expected 0", frame_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL rmid_perr: got %b expected 0", parity_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rmid_overrun: got %b expected 0", overrun); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy: got %b expected 1", busy); end
        idle(200);
        checks++; if (nbytes !== n0) begin errors++; $display("FAIL rmid_no_false_byte: got %0d expected 0", nbytes - n0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_high: got %b expected 0", busy); end
        send_frame(1'b0, 8'h81, 1'b0, 1'b1, 1'b0);
        idle(100);
        checks++; if (nbytes !== n0 + 1) begin errors++; $display("FAIL rmid_next_count: got %0d expected 1", nbytes - n0); end
        checks++; if (last_data !== 8'h81) begin errors++; $display("FAIL rmid_next_data: got %h expected 81", last_data); end
        checks++; if (last_ferr !== 1'b0) begin errors++; $display("FAIL rmid_next_ferr: got %b expected 0", last_ferr); end
    endtask

    initial begin
        rst      = 1'b0;
        rx       = 1'b1;
        rx_p     = 1'b1;
        rx_ready = 1'b1;
        ready_p  = 1'b1;
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_break();
        test_overrun();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
